seq_div_32: RTL and testbench

Multi-cycle signed divider that replaces the single-cycle combinational divide path feeding the datapath ALU's DIV operation. It accepts a dividend/divisor pair on a start pulse and iterates one restoring-division step per clock. It returns a truncated quotient and a remainder, which the ALU packs as C[31:0] = quotient and C[63:32] = remainder before the Z/HI/LO write. A start/busy/done handshake lets the control unit stall its DIV step sequence until the result is valid.

---
 rtl/alu_pkg.sv | 16 +
 rtl/div_step.sv | 23 ++
 rtl/seq_div_32.sv | 126 ++++++++++++
 tb/tb_seq_div_32.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, divider state encoding and sizing
package alu_pkg;

   localparam int         DIV_WIDTH   = 32;
   localparam int         DIV_LATENCY = DIV_WIDTH + 2;
   localparam logic [4:0] DIV_OP      = 5'b10000;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ITER,
      FIX,
      DONE
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step on the magnitude path
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   p_in,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] dvs_mag,
   output logic [WIDTH:0]   p_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // A set top bit of p_in means the shifted value overflowed, so it certainly exceeds the divisor
   always_comb begin
      shifted = {p_in[WIDTH-1:0], q_msb};
      diff    = shifted - {1'b0, dvs_mag};
      q_bit   = p_in[WIDTH] | (shifted >= {1'b0, dvs_mag});
      p_next  = q_bit ? diff : shifted;
   end

endmodule

// File: rtl/seq_div_32.sv
// rtl/seq_div_32.sv - multi-cycle signed divider, one restoring step per clock
module seq_div_32
   import alu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH) + 1;

   div_state_e       state, next_state;
   logic             busy_d, done_d;
   logic             accept;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   p_reg;
   logic [WIDTH:0]   p_next;
   logic             q_bit;
   logic             sign_a, sign_b;
   logic [CW-1:0]    count;

   assign accept = start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

   // A zero divisor skips ITER and takes FIX as its single busy cycle
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = start ? PREP : IDLE;
         PREP:    next_state = (dvs_mag == '0) ? FIX : ITER;
         ITER:    next_state = (count == CW'(WIDTH - 1)) ? FIX : ITER;
         FIX:     next_state = DONE;
         DONE:    next_state = start ? PREP : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // busy and done are registered off next_state so they carry no input-to-output path
   always_comb begin
      busy_d = (next_state == ITER) || (next_state == FIX);
      done_d = (next_state == DONE);
   end

   div_step #(
      .WIDTH(WIDTH)
   ) u_div_step (
      .p_in   (p_reg),
      .q_msb  (q_reg[WIDTH-1]),
      .dvs_mag(dvs_mag),
      .p_next (p_next),
      .q_bit  (q_bit)
   );

   // q_reg and dvs_mag hold the raw operands until PREP turns them into magnitudes
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q_reg       <= '0;
         dvs_mag     <= '0;
         p_reg       <= '0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         count       <= '0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  q_reg       <= dividend;
                  dvs_mag     <= divisor;
                  sign_a      <= dividend[WIDTH-1];
                  sign_b      <= divisor[WIDTH-1];
                  div_by_zero <= 1'b0;
               end
            end
            PREP: begin
               if (dvs_mag != '0) begin
                  q_reg   <= sign_a ? -q_reg : q_reg;
                  dvs_mag <= sign_b ? -dvs_mag : dvs_mag;
                  p_reg   <= '0;
                  count   <= '0;
               end
            end
            ITER: begin
               p_reg <= p_next;
               q_reg <= {q_reg[WIDTH-2:0], q_bit};
               count <= count + 1'b1;
            end
            FIX: begin
               if (dvs_mag == '0) begin
                  quotient    <= '1;
                  remainder   <= q_reg;
                  div_by_zero <= 1'b1;
               end else begin
                  quotient  <= (sign_a ^ sign_b) ? -q_reg : q_reg;
                  remainder <= sign_a ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div_32.sv
// tb/tb_seq_div_32.sv - self-checking bench for seq_div_32
module tb_seq_div_32;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int total = 0;
   int bad = 0;

   seq_div_32 dut (
      .clk        (clk),
      .clr        (clr),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_div(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] q, output logic [31:0] r, output bit dz);
      longint la, lb, lq, lr;
      if (b == 32'd0) begin
         q  = 32'hFFFF_FFFF;
         r  = a;
         dz = 1'b1;
      end else begin
         la = longint'($signed(a));
         lb = longint'($signed(b));
         lq = la / lb;
         lr = la % lb;
         q  = lq[31:0];
         r  = lr[31:0];
         dz = 1'b0;
      end
   endtask

   // Transaction-level model: one accepted request, a fixed latency, then a result
   bit          m_active = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
   int          m_cnt = 0, m_lat = 0;
   logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_cnt    = 0;
         m_q      = '0;
         m_r      = '0;
         m_dz     = 1'b0;
      end else if (m_active) begin
         m_cnt++;
         if (m_cnt == m_lat) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_q      = p_q;
            m_r      = p_r;
            m_dz     = p_dz;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            m_active = 1'b1;
            m_cnt    = 0;
            m_dz     = 1'b0;
            model_div(dividend, divisor, p_q, p_r, p_dz);
            m_lat = p_dz ? 2 : DIV_LATENCY;
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_busy", 32'(busy), 32'(m_active && (m_cnt >= 1)));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_dz", 32'(div_by_zero), 32'(m_dz));
      chk("cyc_quotient", quotient, m_q);
      chk("cyc_remainder", remainder, m_r);
   end

   // Called #1 after a posedge; leaves the bench #1 after the accepting edge
   task automatic do_start(input logic [31:0] a, input logic [31:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int cyc0,
                            input logic [31:0] eq, input logic [31:0] er, input logic edz,
                            input int elat, input int ebusy);
      int cyc = cyc0;
      int bcnt = 0;
      if (busy) bcnt++;
      while (!done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (busy) bcnt++;
      end
      chk({name, "_done"}, 32'(done), 32'd1);
      chk({name, "_latency"}, 32'(cyc), 32'(elat));
      chk({name, "_quotient"}, quotient, eq);
      chk({name, "_remainder"}, remainder, er);
      chk({name, "_dz"}, 32'(div_by_zero), 32'(edz));
      if (ebusy >= 0) chk({name, "_busy_cycles"}, 32'(bcnt), 32'(ebusy));
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dz", 32'(div_by_zero), 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      settle();
      clr = 1'b1;
      settle();

      do_start(32'd100, 32'd7);
      wait_done("pos_pos", 0, 32'd14, 32'd2, 1'b0, 34, 33);
      settle();

      do_start(-32'sd100, 32'd7);
      wait_done("neg_pos", 0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, 33);
      settle();

      do_start(32'd100, -32'sd7);
      wait_done("pos_neg", 0, 32'hFFFF_FFF2, 32'd2, 1'b0, 34, 33);
      settle();

      do_start(-32'sd7, -32'sd2);
      wait_done("neg_neg", 0, 32'd3, 32'hFFFF_FFFF, 1'b0, 34, 33);
      settle();

      do_start(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("overflow", 0, 32'h8000_0000, 32'd0, 1'b0, 34, 33);
      settle();

      do_start(32'h7FFF_FFFF, 32'd1);
      wait_done("max_by_1", 0, 32'h7FFF_FFFF, 32'd0, 1'b0, 34, 33);
      settle();

      do_start(32'd5, 32'd0);
      wait_done("div0", 0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, 1);
      // Back-to-back: the new request is issued in the DONE cycle
      do_start(32'd9, 32'd3);
      chk("b2b_done_fell", 32'(done), 32'd0);
      chk("b2b_dz_cleared", 32'(div_by_zero), 32'd0);
      wait_done("b2b", 0, 32'd3, 32'd0, 1'b0, 34, 33);
      settle();

      do_start(32'd1000, 32'd10);
      repeat (4) settle();
      dividend = 32'd7;
      divisor  = 32'd7;
      start    = 1'b1;
      settle();
      start = 1'b0;
      wait_done("ignore_start", 5, 32'd100, 32'd0, 1'b0, 34, -1);
      settle();

      do_start(32'd1000, 32'd10);
      repeat (10) settle();
      clr = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_quotient", quotient, 32'd0);
      chk("abort_remainder", remainder, 32'd0);
      settle();
      clr = 1'b1;
      settle();
      do_start(32'd6, 32'd4);
      wait_done("after_abort", 0, 32'd1, 32'd2, 1'b0, 34, 33);
      repeat (3) settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
